minilcd_fill: RTL and testbench
===============================

Name: minilcd_fill

Overview:
- Rectangle fill engine directly upstream of the 128x128 MiniLCD controller; drives its VRAM write port (VRAM_ADDR/VRAM_DATA/VRAM_WE).
- Accepts fill commands (origin, size, 4-bit colour) from the CPU/MMIO side into a small command FIFO.
- Expands each command into one VRAM pixel write per clock, row-major, clipped to the 128x128 screen.
- Frees the CPU from per-pixel stores for clears, boxes and bars.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, at least 2.

Ports:
CLK  in  1  system clock
RST_X  in  1  asynchronous active-low reset
CMD_VALID  in  1  command offered this cycle
CMD_READY  out  1  FIFO can accept; equals not-full
CMD_X0  in  7  left column, 0..127
CMD_Y0  in  7  top row, 0..127
CMD_W  in  8  width in pixels, 0..255
CMD_H  in  8  height in pixels, 0..255
CMD_COLOR  in  4  pixel value written to VRAM
CMD_MODE  in  1  pattern select; used only with MINILCD_FILL_CHECKER_EN
VRAM_ADDR  out  14  {row[6:0], col[6:0]}, matches controller scan order
VRAM_DATA  out  4  pixel value
VRAM_WE  out  1  write strobe, one pixel per cycle
BUSY  out  1  FIFO non-empty or engine not IDLE
DONE  out  1  one-cycle pulse per completed command

Behaviour:
- Clock and reset: single clock CLK; reset RST_X is asynchronous, active-low.
- Reset values: all outputs 0 except CMD_READY=1. FIFO is emptied, state is IDLE.
- Reset mid-fill: aborts the fill. Pixels already written stay in VRAM; no DONE pulse.
- Accept: a command is accepted on a rising edge where CMD_VALID=1 and CMD_READY=1. Command fields are sampled at that edge.
- FIFO: DEPTH entries, first in first out. CMD_READY is registered, =0 exactly when DEPTH entries are held.
- Simultaneous push and pop when full: allowed, but CMD_READY stays 0 that cycle. Accept is governed by the registered value.
- State IDLE: when the FIFO is non-empty, pop at the next edge and load the counters; go to RUN.
- Clipping at load: ew = min(W, 128-X0), eh = min(H, 128-Y0). Compute with 8-bit unsigned arithmetic; no wrap past column or row 127.
- Zero size: if ew=0 or eh=0, go to FIN with no writes.
- State RUN: each cycle issues one write with VRAM_WE=1, VRAM_ADDR={y,x}, VRAM_DATA=colour. All three are registered outputs.
  - Column x steps X0..X0+ew-1 inside row y, which steps Y0..Y0+eh-1.
  - At the last column x returns to X0 and y increments.
  - After the final pixel the engine goes to FIN.
- State FIN: exactly one cycle, DONE=1, VRAM_WE=0; then IDLE.
- Latency: command accepted at edge k into an empty FIFO with the engine IDLE:
  - pop at edge k+1;
  - first VRAM_WE=1 in the cycle after edge k+2;
  - exactly ew*eh consecutive WE cycles;
  - DONE in the cycle right after the last WE.
- Back-to-back commands: a 2-cycle gap with VRAM_WE=0 (FIN, then IDLE) separates consecutive commands.
- VRAM_WE: never asserted outside RUN.
- VRAM_ADDR/VRAM_DATA: hold their last values when WE=0.
- BUSY: 0 only when the FIFO is empty and the state is IDLE.

Optional Feature:
MINILCD_FILL_CHECKER_EN:
- Defined: CMD_MODE is stored in the FIFO. With MODE=1, pixel data = ((x^y)&1) ? CMD_COLOR : 4'h0; with MODE=0, solid fill.
- Undefined: CMD_MODE is neither stored nor used; every fill is solid. Write timing is identical in both builds.

Test Plan:
- Reset, then X0=0,Y0=0,W=128,H=128,COLOR=5 -> 16384 consecutive WE, addresses 0x0000..0x3FFF in order, data 5, one DONE, BUSY back to 0.
- X0=126,Y0=127,W=4,H=3,COLOR=A -> clip to 2x1: writes 0x3FFE, 0x3FFF only, then DONE.
- Back-to-back: 5 commands of 1x1 pushed with CMD_VALID held high, DEPTH=4, engine stalled on a 2x2 fill -> CMD_READY drops after 4 accepted; all commands execute in order; 6 DONE pulses total.
- W=0,H=9 -> no WE, DONE exactly 2 cycles after pop; next queued command unaffected.
- RST_X low mid-fill of a 10x10 at X0=Y0=20, after 37 writes -> outputs 0 immediately, CMD_READY=1, FIFO empty, no further writes or DONE.
- CHECKER_EN build, X0=0,Y0=0,W=2,H=2,COLOR=F,MODE=1 -> data 0,F,F,0 at 0x0000, 0x0001, 0x0080, 0x0081.

Source files
------------

// File: rtl/minilcd_fill_if.sv
// Command and VRAM-write bundle of the MiniLCD rectangle fill engine.
// slave  : the fill engine (consumes commands, drives the VRAM write port)
// master : the CPU/MMIO side and the VRAM controller as seen by the engine
interface minilcd_fill_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [6:0]  CMD_X0;
  logic [6:0]  CMD_Y0;
  logic [7:0]  CMD_W;
  logic [7:0]  CMD_H;
  logic [3:0]  CMD_COLOR;
  logic        CMD_MODE;
  logic [13:0] VRAM_ADDR;
  logic [3:0]  VRAM_DATA;
  logic        VRAM_WE;
  logic        BUSY;
  logic        DONE;

  modport slave (
    input  CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOR, CMD_MODE,
    output CMD_READY, VRAM_ADDR, VRAM_DATA, VRAM_WE, BUSY, DONE
  );

  modport master (
    output CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOR, CMD_MODE,
    input  CMD_READY, VRAM_ADDR, VRAM_DATA, VRAM_WE, BUSY, DONE
  );
endinterface

// File: rtl/minilcd_fill.sv
// MiniLCD rectangle fill engine: queues fill commands in a DEPTH-entry FIFO
// and expands each one into row-major VRAM pixel writes, one per clock,
// clipped to the 128x128 screen.
// Optional build macro MINILCD_FILL_CHECKER_EN: stores CMD_MODE with each
// command; MODE=1 writes a checkerboard (colour where x^y is odd, else 0).
module minilcd_fill #(
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST_X,
  minilcd_fill_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
`ifdef MINILCD_FILL_CHECKER_EN
  localparam int EW = 35;
`else
  localparam int EW = 34;
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // FIFO storage and control
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          push, pop;
  logic [EW-1:0] wr_entry, head;

  // Head-of-FIFO fields and clipped extents
  logic [6:0] h_x0, h_y0;
  logic [7:0] h_w, h_h;
  logic [3:0] h_color;
  logic [7:0] room_x, room_y, ew, eh;
  logic [6:0] x_last, y_last;

  // Engine state and registered outputs
  state_t      state_q, state_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic [6:0]  x0_q, x0_d, xl_q, xl_d, yl_q, yl_d;
  logic [3:0]  color_q, color_d;
  logic [3:0]  pix;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [3:0]  data_q, data_d;
  logic        done_q, done_d;
`ifdef MINILCD_FILL_CHECKER_EN
  logic        h_mode;
  logic        mode_q, mode_d;
`endif

  // Entry layout: {[mode], colour, h, w, y0, x0}
`ifdef MINILCD_FILL_CHECKER_EN
  assign wr_entry = {bus.CMD_MODE, bus.CMD_COLOR, bus.CMD_H, bus.CMD_W,
                     bus.CMD_Y0, bus.CMD_X0};
  assign h_mode   = head[34];
`else
  assign wr_entry = {bus.CMD_COLOR, bus.CMD_H, bus.CMD_W, bus.CMD_Y0, bus.CMD_X0};
`endif
  assign head    = mem_q[rd_ptr_q];
  assign h_x0    = head[6:0];
  assign h_y0    = head[13:7];
  assign h_w     = head[21:14];
  assign h_h     = head[29:22];
  assign h_color = head[33:30];

  // Accept uses the registered ready; pop happens only from IDLE
  assign push = bus.CMD_VALID && ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  // FIFO pointer/occupancy update; ready reflects next-cycle fullness
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  // Command storage; holds data only, so it needs no reset
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Clip to the screen edge with 8-bit unsigned math. The last column/row
  // always fits in 7 bits, so modulo-128 arithmetic gives it exactly even
  // when the extent is a full 128.
  always_comb begin
    room_x = 8'd128 - {1'b0, h_x0};
    room_y = 8'd128 - {1'b0, h_y0};
    ew     = (h_w < room_x) ? h_w : room_x;
    eh     = (h_h < room_y) ? h_h : room_y;
    x_last = h_x0 + ew[6:0] - 7'd1;
    y_last = h_y0 + eh[6:0] - 7'd1;
  end

  // Pixel value for the current coordinate
  always_comb begin
`ifdef MINILCD_FILL_CHECKER_EN
    pix = (mode_q && !(x_q[0] ^ y_q[0])) ? 4'h0 : color_q;
`else
    pix = color_q;
`endif
  end

  // Engine FSM: load on pop, one write per RUN cycle, one-cycle FIN
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    xl_d    = xl_q;
    yl_d    = yl_q;
    color_d = color_q;
`ifdef MINILCD_FILL_CHECKER_EN
    mode_d  = mode_q;
`endif
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          x_d     = h_x0;
          y_d     = h_y0;
          x0_d    = h_x0;
          xl_d    = x_last;
          yl_d    = y_last;
          color_d = h_color;
`ifdef MINILCD_FILL_CHECKER_EN
          mode_d  = h_mode;
`endif
          state_d = ((ew == 8'd0) || (eh == 8'd0)) ? FIN : RUN;
        end
      end
      RUN: begin
        we_d   = 1'b1;
        addr_d = {y_q, x_q};
        data_d = pix;
        if (x_q == xl_q) begin
          x_d = x0_q;
          if (y_q == yl_q) state_d = FIN;
          else             y_d = y_q + 7'd1;
        end else begin
          x_d = x_q + 7'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, FIFO control and output registers; reset aborts any fill
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      xl_q     <= '0;
      yl_q     <= '0;
      color_q  <= '0;
`ifdef MINILCD_FILL_CHECKER_EN
      mode_q   <= 1'b0;
`endif
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      xl_q     <= xl_d;
      yl_q     <= yl_d;
      color_q  <= color_d;
`ifdef MINILCD_FILL_CHECKER_EN
      mode_q   <= mode_d;
`endif
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign bus.CMD_READY = ready_q;
  assign bus.VRAM_WE   = we_q;
  assign bus.VRAM_ADDR = addr_q;
  assign bus.VRAM_DATA = data_q;
  assign bus.DONE      = done_q;
  assign bus.BUSY      = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_minilcd_fill.sv
// Directed bench for minilcd_fill: reset state, clipping and latency,
// full-screen fill, FIFO back-pressure, zero-size command, pattern mode
// and reset in the middle of a fill.
module tb_minilcd_fill;

  logic clk;
  logic rst_x;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   done_cnt = 0;

  typedef struct {
    logic [13:0] a;
    logic [3:0]  d;
    int          c;
  } wr_t;
  wr_t wq[$];

  minilcd_fill_if bus ();

  minilcd_fill #(.DEPTH(4)) dut (
    .CLK   (clk),
    .RST_X (rst_x),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every VRAM write and DONE pulse mid-cycle
  always @(negedge clk) begin
    if (bus.VRAM_WE === 1'b1) wq.push_back('{a: bus.VRAM_ADDR, d: bus.VRAM_DATA, c: cyc});
    if (bus.DONE === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] x0, input logic [6:0] y0, input logic [7:0] w,
                      input logic [7:0] h, input logic [3:0] col, input logic mode);
    bus.CMD_X0 = x0; bus.CMD_Y0 = y0; bus.CMD_W = w; bus.CMD_H = h;
    bus.CMD_COLOR = col; bus.CMD_MODE = mode; bus.CMD_VALID = 1'b1;
    tick();
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int d0, err_a, err_c, i, guard, first_stall, cnt;
    logic r;
    logic [13:0] exp_a [4];
    logic [3:0]  exp_d [4];

    rst_x = 1'b0;
    bus.CMD_VALID = 1'b0; bus.CMD_X0 = '0; bus.CMD_Y0 = '0; bus.CMD_W = '0;
    bus.CMD_H = '0; bus.CMD_COLOR = '0; bus.CMD_MODE = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(bus.CMD_READY), 32'd1);
    check("rst_we",    32'(bus.VRAM_WE),   32'd0);
    check("rst_addr",  32'(bus.VRAM_ADDR), 32'd0);
    check("rst_data",  32'(bus.VRAM_DATA), 32'd0);
    check("rst_busy",  32'(bus.BUSY),      32'd0);
    check("rst_done",  32'(bus.DONE),      32'd0);
    rst_x = 1'b1;
    tick();

    // Clipped 4x3 at (126,127) -> 2x1; exact latency from accept edge k
    send(7'd126, 7'd127, 8'd4, 8'd3, 4'hA, 1'b0);
    check("clip_busy_k",  32'(bus.BUSY),    32'd1);
    check("clip_we_k",    32'(bus.VRAM_WE), 32'd0);
    tick();
    check("clip_we_k1",   32'(bus.VRAM_WE), 32'd0);
    tick();
    check("clip_we_k2",   32'(bus.VRAM_WE),   32'd1);
    check("clip_addr0",   32'(bus.VRAM_ADDR), 32'h3FFE);
    check("clip_data0",   32'(bus.VRAM_DATA), 32'hA);
    tick();
    check("clip_we_k3",   32'(bus.VRAM_WE),   32'd1);
    check("clip_addr1",   32'(bus.VRAM_ADDR), 32'h3FFF);
    tick();
    check("clip_we_k4",   32'(bus.VRAM_WE),   32'd0);
    check("clip_done",    32'(bus.DONE),      32'd1);
    check("clip_hold",    32'(bus.VRAM_ADDR), 32'h3FFF);
    tick();
    check("clip_done_end", 32'(bus.DONE), 32'd0);
    check("clip_idle",     32'(bus.BUSY), 32'd0);
    check("clip_writes",   32'(wq.size()), 32'd2);

    // Full screen clear
    tick();
    wq.delete(); d0 = done_cnt;
    send(7'd0, 7'd0, 8'd128, 8'd128, 4'h5, 1'b0);
    wait_done(d0 + 1, 17000, "full_timeout");
    tick(); tick();
    err_a = 0; err_c = 0;
    for (int k = 0; k < wq.size(); k++) begin
      if (wq[k].a !== 14'(k) || wq[k].d !== 4'h5) err_a++;
      if (k > 0 && wq[k].c != wq[k-1].c + 1) err_c++;
    end
    check("full_count",   32'(wq.size()), 32'd16384);
    check("full_addr",    32'(err_a), 32'd0);
    check("full_consec",  32'(err_c), 32'd0);
    check("full_done1",   32'(done_cnt - d0), 32'd1);
    check("full_busy",    32'(bus.BUSY), 32'd0);

    // Back-pressure: 2x2 then five 1x1 with VALID held
    wq.delete(); d0 = done_cnt;
    send(7'd10, 7'd10, 8'd2, 8'd2, 4'h1, 1'b0);
    i = 0; guard = 0; first_stall = -1;
    while (i < 5 && guard < 100) begin
      bus.CMD_X0 = 7'(i * 3); bus.CMD_Y0 = 7'd5; bus.CMD_W = 8'd1; bus.CMD_H = 8'd1;
      bus.CMD_COLOR = 4'(i + 2); bus.CMD_VALID = 1'b1;
      r = bus.CMD_READY;
      if (!r && first_stall < 0) first_stall = i;
      tick();
      if (r) i++;
      guard++;
    end
    bus.CMD_VALID = 1'b0;
    check("b2b_all_accepted", 32'(i), 32'd5);
    check("b2b_stall_after",  32'(first_stall), 32'd4);
    wait_done(d0 + 6, 300, "b2b_timeout");
    tick(); tick(); tick(); tick();
    check("b2b_done6",  32'(done_cnt - d0), 32'd6);
    check("b2b_writes", 32'(wq.size()), 32'd9);
    if (wq.size() == 9) begin
      check("b2b_a0", 32'(wq[0].a), 32'd1290);
      check("b2b_a1", 32'(wq[1].a), 32'd1291);
      check("b2b_a2", 32'(wq[2].a), 32'd1418);
      check("b2b_a3", 32'(wq[3].a), 32'd1419);
      err_a = 0;
      for (int k = 0; k < 5; k++)
        if (wq[4+k].a !== 14'(640 + 3 * k) || wq[4+k].d !== 4'(k + 2)) err_a++;
      check("b2b_order", 32'(err_a), 32'd0);
      check("b2b_gap",   32'(wq[4].c - wq[3].c), 32'd3);
    end

    // Zero width, next command queued behind it
    wq.delete(); d0 = done_cnt;
    send(7'd0, 7'd0, 8'd0, 8'd9, 4'hC, 1'b0);
    send(7'd3, 7'd4, 8'd1, 8'd1, 4'h7, 1'b0);
    check("zero_we_k1",   32'(bus.VRAM_WE), 32'd0);
    check("zero_done_k1", 32'(bus.DONE),    32'd0);
    tick();
    check("zero_done_k2", 32'(bus.DONE),    32'd1);
    check("zero_we_k2",   32'(bus.VRAM_WE), 32'd0);
    tick();
    check("zero_done_k3", 32'(bus.DONE),    32'd0);
    wait_done(d0 + 2, 50, "zero_timeout");
    check("zero_writes", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      check("zero_next_addr", 32'(wq[0].a), 32'h203);
      check("zero_next_data", 32'(wq[0].d), 32'h7);
    end

    // Pattern mode 2x2 (solid when the pattern feature is not built)
    tick();
    wq.delete(); d0 = done_cnt;
    send(7'd0, 7'd0, 8'd2, 8'd2, 4'hF, 1'b1);
    wait_done(d0 + 1, 50, "pat_timeout");
    exp_a[0] = 14'h0000; exp_a[1] = 14'h0001; exp_a[2] = 14'h0080; exp_a[3] = 14'h0081;
`ifdef MINILCD_FILL_CHECKER_EN
    exp_d[0] = 4'h0; exp_d[1] = 4'hF; exp_d[2] = 4'hF; exp_d[3] = 4'h0;
`else
    exp_d[0] = 4'hF; exp_d[1] = 4'hF; exp_d[2] = 4'hF; exp_d[3] = 4'hF;
`endif
    check("pat_writes", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      err_a = 0;
      for (int k = 0; k < 4; k++)
        if (wq[k].a !== exp_a[k] || wq[k].d !== exp_d[k]) err_a++;
      check("pat_pixels", 32'(err_a), 32'd0);
    end

    // Reset after 37 writes of a 10x10 at (20,20) with another command queued
    tick();
    wq.delete(); d0 = done_cnt;
    send(7'd20, 7'd20, 8'd10, 8'd10, 4'h3, 1'b0);
    send(7'd0, 7'd0, 8'd1, 8'd1, 4'h9, 1'b0);
    cnt = 0; guard = 0;
    while (cnt < 37 && guard < 200) begin
      tick();
      if (bus.VRAM_WE === 1'b1) cnt++;
      guard++;
    end
    check("rmid_reached", 32'(cnt), 32'd37);
    @(negedge clk);
    #1;
    rst_x = 1'b0;
    #1;
    check("rmid_we",    32'(bus.VRAM_WE),   32'd0);
    check("rmid_addr",  32'(bus.VRAM_ADDR), 32'd0);
    check("rmid_data",  32'(bus.VRAM_DATA), 32'd0);
    check("rmid_ready", 32'(bus.CMD_READY), 32'd1);
    check("rmid_busy",  32'(bus.BUSY),      32'd0);
    check("rmid_done",  32'(bus.DONE),      32'd0);
    tick();
    rst_x = 1'b1;
    repeat (20) tick();
    check("rmid_writes",  32'(wq.size()), 32'd37);
    if (wq.size() == 37) check("rmid_last_addr", 32'(wq[36].a), 32'd2970);
    check("rmid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rmid_idle",    32'(bus.BUSY), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
